open_loop_rx_multiq_sched: RTL

Parametrised receive-side scheduler for open-loop TCP apps: it serves NUM_Q receive-flow queues instead of one, round-robin. Per grant it reads the flow's app state and issues one bounded read request (at most MAX_REQ_BYTES) to the RX circular-buffer reader. It then writes back the advanced pointer and remaining count, and either requeues the flow to its own queue or emits a completion notification. It sits between the per-core receive queues, the app-state RAM and the rd-buffer request port of the RX engine.

---
 rtl/open_loop_pkg.sv | 30 +++
 rtl/open_loop_rx_rr_arb.sv | 31 +++
 rtl/open_loop_rx_multiq_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/open_loop_pkg.sv
// open_loop_pkg: shared types and helpers for the open-loop receive scheduler
package open_loop_pkg;
   // Flow context fields are stored at their widest supported width; users slice them down.
   localparam int RX_FLOWID_MAX = 32;
   localparam int RX_QIDX_MAX   = 8;
   localparam int RX_PTR_MAX    = 32;
   localparam int RX_LEN_MAX    = 64;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_ST_REQ,
      RX_ST_RESP,
      RX_ISSUE,
      RX_WRITEBACK,
      RX_REQUEUE,
      RX_NOTIFY
   } rx_sched_state_e;

   typedef struct packed {
      logic [RX_FLOWID_MAX-1:0] flowid;
      logic [RX_QIDX_MAX-1:0]   qidx;
      logic [RX_PTR_MAX-1:0]    ptr;
      logic [RX_LEN_MAX-1:0]    left;
   } rx_sched_flow_struct;

   // Width of a queue index; a single queue still needs one bit.
   function automatic int rx_qidx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/open_loop_rx_rr_arb.sv
// open_loop_rx_rr_arb: round-robin arbiter over NUM_Q queue requests starting at rr_ptr
module open_loop_rx_rr_arb import open_loop_pkg::*; #(
   parameter int NUM_Q = 4
) (
   input  logic [NUM_Q-1:0]              req,
   input  logic [rx_qidx_w(NUM_Q)-1:0]   rr_ptr,
   input  logic                          advance,
   output logic [NUM_Q-1:0]              grant_oh,
   output logic [rx_qidx_w(NUM_Q)-1:0]   grant_idx,
   output logic                          any
);
   localparam int QW = rx_qidx_w(NUM_Q);

   // Scan offsets from farthest to nearest so the nearest requester at/after rr_ptr wins.
   always_comb begin
      int j;
      j = 0;
      grant_idx = '0;
      any = 1'b0;
      for (int k = NUM_Q - 1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_Q) j = j - NUM_Q;
         if (req[j]) begin
            grant_idx = QW'(j);
            any = 1'b1;
         end
      end
   end

   assign grant_oh = (advance && any) ? (NUM_Q'(1) << grant_idx) : '0;
endmodule

// File: rtl/open_loop_rx_multiq_sched.sv
// open_loop_rx_multiq_sched: round-robin multi-queue receive scheduler issuing bounded buffer reads
module open_loop_rx_multiq_sched import open_loop_pkg::*; #(
   parameter int NUM_Q         = 4,
   parameter int FLOWID_W      = 13,
   parameter int PTR_W         = 16,
   parameter int LEN_W         = 32,
   parameter int SIZE_W        = 16,
   parameter int MAX_REQ_BYTES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [NUM_Q-1:0]              q_empty,
   input  logic [NUM_Q*FLOWID_W-1:0]     q_rd_data,
   output logic [NUM_Q-1:0]              q_rd_req,
   input  logic [NUM_Q-1:0]              q_full,
   output logic [NUM_Q-1:0]              q_wr_req,
   output logic [FLOWID_W-1:0]           q_wr_data,
   output logic                          st_rd_req_val,
   input  logic                          st_rd_req_rdy,
   output logic [FLOWID_W-1:0]           st_rd_req_flowid,
   input  logic                          st_rd_resp_val,
   output logic                          st_rd_resp_rdy,
   input  logic [PTR_W-1:0]              st_rd_resp_ptr,
   input  logic [LEN_W-1:0]              st_rd_resp_left,
   output logic                          st_wr_val,
   output logic [FLOWID_W-1:0]           st_wr_flowid,
   output logic [PTR_W-1:0]              st_wr_ptr,
   output logic [LEN_W-1:0]              st_wr_left,
   output logic                          rd_req_val,
   input  logic                          rd_req_rdy,
   output logic [FLOWID_W-1:0]           rd_req_flowid,
   output logic [PTR_W-1:0]              rd_req_offset,
   output logic [SIZE_W-1:0]             rd_req_size,
   output logic                          done_val,
   input  logic                          done_rdy,
   output logic [FLOWID_W-1:0]           done_flowid,
   output logic [rx_qidx_w(NUM_Q)-1:0]   done_q
);
   localparam int QW = rx_qidx_w(NUM_Q);

   rx_sched_state_e     state_q, state_d;
   logic [QW-1:0]       rr_ptr_q, rr_ptr_d;
   rx_sched_flow_struct flow_q, flow_d;
   logic [SIZE_W-1:0]   size_q, size_d;

   logic [NUM_Q-1:0]    grant_oh;
   logic [QW-1:0]       grant_idx;
   logic                any_req;
   logic                advance;
   logic [FLOWID_W-1:0] head, flowid;
   logic [QW-1:0]       qidx;
   logic [PTR_W-1:0]    ptr, new_ptr;
   logic [LEN_W-1:0]    left, new_left;
   logic [SIZE_W-1:0]   resp_size;
   logic                unused_flow_bits;

   // Only the low bits of the wide flow context are meaningful for this instance.
   assign flowid           = flow_q.flowid[FLOWID_W-1:0];
   assign qidx             = flow_q.qidx[QW-1:0];
   assign ptr              = flow_q.ptr[PTR_W-1:0];
   assign left             = flow_q.left[LEN_W-1:0];
   assign unused_flow_bits = ^flow_q;

   // Reset also gates the pop so nothing leaves a queue while the block is held in reset.
   assign advance = rst_n && enable && (state_q == RX_IDLE);
   assign head    = q_rd_data[grant_idx*FLOWID_W +: FLOWID_W];

   open_loop_rx_rr_arb #(.NUM_Q(NUM_Q)) u_arb (
      .req       (~q_empty),
      .rr_ptr    (rr_ptr_q),
      .advance   (advance),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .any       (any_req)
   );

   // Chunk size is capped; when left is below the cap it already fits in SIZE_W.
   assign resp_size = (st_rd_resp_left >= LEN_W'(MAX_REQ_BYTES)) ? SIZE_W'(MAX_REQ_BYTES)
                                                                  : SIZE_W'(st_rd_resp_left);
   assign new_ptr   = ptr + PTR_W'(size_q);
   assign new_left  = left - LEN_W'(size_q);

   // Next-state and flow-context update for one grant's walk through the FSM.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      flow_d   = flow_q;
      size_d   = size_q;
      case (state_q)
         RX_IDLE: if (advance && any_req) begin
            flow_d.flowid = RX_FLOWID_MAX'(head);
            flow_d.qidx   = RX_QIDX_MAX'(grant_idx);
            rr_ptr_d      = (grant_idx == QW'(NUM_Q - 1)) ? '0 : grant_idx + QW'(1);
            state_d       = RX_ST_REQ;
         end
         RX_ST_REQ: state_d = st_rd_req_rdy ? RX_ST_RESP : RX_ST_REQ;
         RX_ST_RESP: if (st_rd_resp_val) begin
            flow_d.ptr  = RX_PTR_MAX'(st_rd_resp_ptr);
            flow_d.left = RX_LEN_MAX'(st_rd_resp_left);
            size_d      = resp_size;
            state_d     = (st_rd_resp_left == '0) ? RX_NOTIFY : RX_ISSUE;
         end
         RX_ISSUE: state_d = rd_req_rdy ? RX_WRITEBACK : RX_ISSUE;
         RX_WRITEBACK: begin
            flow_d.ptr  = RX_PTR_MAX'(new_ptr);
            flow_d.left = RX_LEN_MAX'(new_left);
            state_d     = (new_left != '0) ? RX_REQUEUE : RX_NOTIFY;
         end
         RX_REQUEUE: state_d = q_full[qidx] ? RX_REQUEUE : RX_IDLE;
         RX_NOTIFY: state_d = done_rdy ? RX_IDLE : RX_NOTIFY;
         default: state_d = RX_IDLE;
      endcase
   end

   // Scheduler state, round-robin pointer and latched flow context.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RX_IDLE;
         rr_ptr_q <= '0;
         flow_q   <= '0;
         size_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         flow_q   <= flow_d;
         size_q   <= size_d;
      end
   end

   assign q_rd_req         = grant_oh;
   assign q_wr_req         = (state_q == RX_REQUEUE && !q_full[qidx]) ? (NUM_Q'(1) << qidx) : '0;
   assign q_wr_data        = flowid;
   assign st_rd_req_val    = (state_q == RX_ST_REQ);
   assign st_rd_req_flowid = flowid;
   assign st_rd_resp_rdy   = (state_q == RX_ST_RESP);
   assign st_wr_val        = (state_q == RX_WRITEBACK);
   assign st_wr_flowid     = flowid;
   assign st_wr_ptr        = new_ptr;
   assign st_wr_left       = new_left;
   assign rd_req_val       = (state_q == RX_ISSUE);
   assign rd_req_flowid    = flowid;
   assign rd_req_offset    = ptr;
   assign rd_req_size      = size_q;
   assign done_val         = (state_q == RX_NOTIFY);
   assign done_flowid      = flowid;
   assign done_q           = qidx;
endmodule
